shift_rows_stream: RTL and testbench
====================================

# shift_rows_stream

Parametrised, stream-handshaked Rijndael ShiftRows / InvShiftRows stage. It supports state widths of 4, 6 or 8 columns, selected by a parameter. The direction (forward or inverse) is chosen per beat, so one instance serves both the encrypt and decrypt round datapaths. A 2-entry output buffer decouples upstream from downstream back-pressure. The block sits between SubBytes and MixColumns in the round pipeline, and a tag travels alongside each beat for round/context tracking.

## Interface
- `NB`, default 4: state columns; legal values 4, 6, 8. Data width `W = 32*NB`.
- `TAG_W`, default 4: width of the sideband tag carried with each beat.
- `clk` in 1: sole clock; all logic is on its rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `in_valid` in 1: upstream beat valid.
- `in_ready` out 1: stage can accept a beat.
- `in_data` in W: input state.
- `in_inv` in 1: 0 = ShiftRows, 1 = InvShiftRows; sampled with the beat.
- `in_tag` in TAG_W: sideband carried unchanged with the beat.
- `out_valid` out 1: output beat valid.
- `out_ready` in 1: downstream accepts.
- `out_data` out W: permuted state.
- `out_tag` out TAG_W: tag of the current output beat.
- `occupancy` out 2: number of beats held, 0..2.

## Operation
- Byte layout is column-major, MSB first: byte k = `data[W-1-8k -: 8]`, with row r = k mod 4 and column c = k div 4.
- Row offsets s[r]:
  - NB=4 or 6: 0,1,2,3.
  - NB=8: 0,1,3,4.
- Forward: out(r,c) = in(r, (c + s[r]) mod NB).
- Inverse: out(r,c) = in(r, (c − s[r] + NB) mod NB).
- The permutation is pure wiring and is applied before storage. The buffer holds permuted data plus tag.
- Accept when `in_valid && in_ready`. Emit when `out_valid && out_ready`.
- The buffer is a 2-entry FIFO: write pointer, read pointer (1 bit each) and a 2-bit count.
  - Accept only: count +1.
  - Emit only: count −1.
  - Both in the same cycle: count unchanged; the beats remain in FIFO order.
- `in_ready` is a register. Its next value is (next count < 2), except that it is held at 0 during reset. It never depends combinationally on `out_ready`.
- `out_valid` = (count != 0). `out_data`/`out_tag` are the head entry.
- Full (count = 2): `in_ready` = 0, so upstream stalls. A simultaneous emit frees one slot, and `in_ready` returns to 1 on the next edge.
- Empty: `out_valid` = 0. `out_data` holds the last head value; its content is don't-care.
- Illegal NB is an elaboration error, raised via a generate-time check.
- Data and tag are never modified except by the permutation.

## Timing
- Reset values: `in_ready`=0, `out_valid`=0, `out_data`=0, `out_tag`=0, `occupancy`=0, pointers 0. All take effect immediately on `rst` assertion.
- `in_ready` rises on the first `clk` edge after `rst` deasserts.
- Latency: a beat accepted at edge N drives `out_valid` high after edge N, and is presentable for emission at edge N+1.
- Throughput is 1 beat/cycle while `out_ready` = 1.
- Reset mid-operation discards all buffered beats. No partial beat is emitted.
- `out_valid`, `out_data` and `out_tag` must hold stable while `out_valid && !out_ready`.

## Structure
- Shared package `aes_pkg`:
  - `NB_MIN`/`NB_MAX` constants.
  - Function `shift_offset(nb, row)` returning s[r].
  - Byte-index helper `byte_idx(nb, row, col)`.
- Combinational sub-module `rijndael_shift_perm`, with parameter `NB` and ports `inv`, `din`, `dout`. The top level is the FIFO plus handshake around it. The sub-module is reusable by the key-schedule/round-unrolled builds.

## Test plan
- NB=4, forward, in `0x00112233445566778899aabbccddeeff` → out `0x0055aaff4499ee3388dd2277cc1166bb`, one cycle later, with `out_tag` equal to `in_tag`.
- NB=4, inverse, in `0x00112233445566778899aabbccddeeff` → out `0x00ddaa774411eebb885522ffcc996633`. Also check that forward then inverse round-trips to the input.
- NB=8: forward then inverse on random data returns the input. Bytes 0 (r0,c0) and 5 (r1,c1) map to positions 0 and 1 respectively, per offset 1.
- Back-pressure: hold `out_ready`=0 and offer 3 beats (tags 1,2,3).
  - `in_ready` drops after 2 accepts.
  - `occupancy`=2.
  - Releasing `out_ready` emits tags 1,2,3 in order with no loss or duplication.
- Simultaneous accept/emit at count=1 over 20 consecutive beats: `occupancy` stays 1, one beat per cycle, order preserved.
- Assert `rst` with count=2:
  - `out_valid`/`occupancy`/`in_ready` go to 0 without waiting for a clock edge.
  - After release, `in_ready`=1 at the next edge, and the first new beat is output with no stale data.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared Rijndael helpers: legal state widths, ShiftRows row offsets and
// the column-major byte indexing used by every stage of the round datapath.
package aes_pkg;

    localparam int NB_MIN = 4;
    localparam int NB_MAX = 8;

    // A state width is legal when it is 4, 6 or 8 columns.
    function automatic bit nb_legal(input int nb);
        return (nb >= NB_MIN) && (nb <= NB_MAX) && ((nb % 2) == 0);
    endfunction

    // Row rotation amount; the 8-column state skips offset 2.
    function automatic int shift_offset(input int nb, input int row);
        if ((nb == 8) && (row >= 2)) begin
            return row + 1;
        end
        return row;
    endfunction

    // Byte index of (row, col) in a column-major state; col wraps modulo nb
    // so callers can pass rotated column numbers directly.
    function automatic int byte_idx(input int nb, input int row, input int col);
        return ((col % nb) * 4) + row;
    endfunction

endpackage

// File: rtl/shift_rows_stream_if.sv
// Stream bundle for the ShiftRows stage: upstream beat, downstream beat and
// the buffer fill level. The producer/consumer side of the bench uses
// master, the stage itself uses slave.
interface shift_rows_stream_if #(
    parameter int NB    = 4,
    parameter int TAG_W = 4
);
    localparam int W = 32 * NB;

    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_data;
    logic             in_inv;
    logic [TAG_W-1:0] in_tag;

    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     out_data;
    logic [TAG_W-1:0] out_tag;

    logic [1:0]       occupancy;

    modport master (
        output in_valid, in_data, in_inv, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_tag, occupancy
    );

    modport slave (
        input  in_valid, in_data, in_inv, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_tag, occupancy
    );

endinterface

// File: rtl/rijndael_shift_perm.sv
// Combinational ShiftRows / InvShiftRows byte permutation. Pure wiring plus
// one 2:1 mux per byte, so it can be dropped into unrolled round builds.
module rijndael_shift_perm
    import aes_pkg::*;
#(
    parameter int NB = 4
) (
    input  logic              inv,
    input  logic [32*NB-1:0]  din,
    output logic [32*NB-1:0]  dout
);
    localparam int W = 32 * NB;

    // Refuse to elaborate for state widths Rijndael does not define.
    if (!nb_legal(NB)) begin : g_bad_nb
        $error("rijndael_shift_perm: NB must be 4, 6 or 8");
    end

    // Each output byte picks its source column rotated left (forward) or
    // right (inverse) by the row offset.
    for (genvar r = 0; r < 4; r++) begin : g_row
        for (genvar c = 0; c < NB; c++) begin : g_col
            localparam int DST     = byte_idx(NB, r, c);
            localparam int SRC_FWD = byte_idx(NB, r, c + shift_offset(NB, r));
            localparam int SRC_INV = byte_idx(NB, r, c - shift_offset(NB, r) + NB);

            assign dout[W-1-8*DST -: 8] = inv ? din[W-1-8*SRC_INV -: 8]
                                              : din[W-1-8*SRC_FWD -: 8];
        end
    end

endmodule

// File: rtl/shift_rows_stream.sv
// Stream-handshaked ShiftRows stage: permutes each beat on the way in and
// parks it in a 2-entry FIFO so upstream never sees downstream stalls
// combinationally.
module shift_rows_stream
    import aes_pkg::*;
#(
    parameter int NB    = 4,
    parameter int TAG_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    shift_rows_stream_if.slave bus
);
    localparam int W = 32 * NB;

    logic [W-1:0]     perm_data;

    logic [W-1:0]     data_q [2];
    logic [W-1:0]     data_d [2];
    logic [TAG_W-1:0] tag_q  [2];
    logic [TAG_W-1:0] tag_d  [2];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       count_q, count_d;
    logic             in_ready_q, in_ready_d;
    logic             accept;
    logic             emit;

    rijndael_shift_perm #(
        .NB (NB)
    ) u_perm (
        .inv  (bus.in_inv),
        .din  (bus.in_data),
        .dout (perm_data)
    );

    // FIFO bookkeeping: write the permuted beat on accept, advance the head
    // on emit, and precompute next-cycle readiness from the next count.
    always_comb begin
        accept     = bus.in_valid && in_ready_q;
        emit       = (count_q != 2'd0) && bus.out_ready;
        data_d     = data_q;
        tag_d      = tag_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;

        if (accept) begin
            data_d[wr_ptr_q] = perm_data;
            tag_d[wr_ptr_q]  = bus.in_tag;
            wr_ptr_d         = ~wr_ptr_q;
        end

        if (emit) begin
            rd_ptr_d = ~rd_ptr_q;
        end

        case ({accept, emit})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase

        in_ready_d = (count_d < 2'd2);
    end

    // State registers; reset empties the buffer and holds in_ready low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q[0]  <= '0;
            data_q[1]  <= '0;
            tag_q[0]   <= '0;
            tag_q[1]   <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
            in_ready_q <= 1'b0;
        end else begin
            data_q[0]  <= data_d[0];
            data_q[1]  <= data_d[1];
            tag_q[0]   <= tag_d[0];
            tag_q[1]   <= tag_d[1];
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = (count_q != 2'd0);
    assign bus.out_data  = data_q[rd_ptr_q];
    assign bus.out_tag   = tag_q[rd_ptr_q];
    assign bus.occupancy = count_q;

endmodule

// File: tb/tb_shift_rows_stream.sv
// Directed bench for shift_rows_stream: NB=4 and NB=8 instances sharing one
// clock and reset.
module tb_shift_rows_stream;

    localparam logic [127:0] VEC_IN  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] VEC_FWD = 128'h0055aaff4499ee3388dd2277cc1166bb;
    localparam logic [127:0] VEC_INV = 128'h00ddaa774411eebb885522ffcc996633;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    shift_rows_stream_if #(.NB(4), .TAG_W(4)) bus4 ();
    shift_rows_stream_if #(.NB(8), .TAG_W(4)) bus8 ();

    shift_rows_stream #(.NB(4), .TAG_W(4)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    shift_rows_stream #(.NB(8), .TAG_W(4)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8)
    );

    function automatic logic [7:0] byte8(input logic [255:0] d, input int k);
        return d[255-8*k -: 8];
    endfunction

    // One beat through the NB=4 instance: capture the head right after accept,
    // then drain it.
    task automatic xfer4(input logic [127:0] d, input logic inv, input logic [3:0] t,
                         output logic [127:0] od, output logic [3:0] ot,
                         output logic ov, output logic [1:0] occ);
        int n = 0;
        while (n < 20 && !bus4.in_ready) begin
            @(posedge clk); #1;
            n++;
        end
        bus4.out_ready = 1'b0;
        bus4.in_data   = d;
        bus4.in_inv    = inv;
        bus4.in_tag    = t;
        bus4.in_valid  = 1'b1;
        @(posedge clk); #1;
        bus4.in_valid  = 1'b0;
        ov  = bus4.out_valid;
        od  = bus4.out_data;
        ot  = bus4.out_tag;
        occ = bus4.occupancy;
        bus4.out_ready = 1'b1;
        @(posedge clk); #1;
        bus4.out_ready = 1'b0;
    endtask

    // Same as xfer4 for the NB=8 instance.
    task automatic xfer8(input logic [255:0] d, input logic inv, input logic [3:0] t,
                         output logic [255:0] od, output logic [3:0] ot,
                         output logic ov);
        int n = 0;
        while (n < 20 && !bus8.in_ready) begin
            @(posedge clk); #1;
            n++;
        end
        bus8.out_ready = 1'b0;
        bus8.in_data   = d;
        bus8.in_inv    = inv;
        bus8.in_tag    = t;
        bus8.in_valid  = 1'b1;
        @(posedge clk); #1;
        bus8.in_valid  = 1'b0;
        ov = bus8.out_valid;
        od = bus8.out_data;
        ot = bus8.out_tag;
        bus8.out_ready = 1'b1;
        @(posedge clk); #1;
        bus8.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus4.in_ready !== 1'b0 || bus8.in_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_in_ready: got %b/%b expected 0/0", bus4.in_ready, bus8.in_ready);
        end
        checks++;
        if (bus4.out_valid !== 1'b0 || bus8.out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_out_valid: got %b/%b expected 0/0", bus4.out_valid, bus8.out_valid);
        end
        checks++;
        if (bus4.occupancy !== 2'd0 || bus8.occupancy !== 2'd0) begin
            errors++;
            $display("[TB] FAIL reset_occupancy: got %0d/%0d expected 0/0", bus4.occupancy, bus8.occupancy);
        end
        checks++;
        if (bus4.out_data !== 128'h0 || bus4.out_tag !== 4'h0) begin
            errors++;
            $display("[TB] FAIL reset_out_data: got %h/%h expected 0/0", bus4.out_data, bus4.out_tag);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (bus4.in_ready !== 1'b1 || bus8.in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL release_in_ready: got %b/%b expected 1/1", bus4.in_ready, bus8.in_ready);
        end
    endtask

    task automatic test_forward_nb4();
        logic [127:0] od;
        logic [3:0]   ot;
        logic         ov;
        logic [1:0]   occ;
        xfer4(VEC_IN, 1'b0, 4'h5, od, ot, ov, occ);
        checks++;
        if (ov !== 1'b1) begin
            errors++;
            $display("[TB] FAIL fwd_valid: got %b expected 1", ov);
        end
        checks++;
        if (od !== VEC_FWD) begin
            errors++;
            $display("[TB] FAIL fwd_data: got %h expected %h", od, VEC_FWD);
        end
        checks++;
        if (ot !== 4'h5) begin
            errors++;
            $display("[TB] FAIL fwd_tag: got %h expected 5", ot);
        end
        checks++;
        if (occ !== 2'd1) begin
            errors++;
            $display("[TB] FAIL fwd_occupancy: got %0d expected 1", occ);
        end
        checks++;
        if (bus4.occupancy !== 2'd0 || bus4.out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL fwd_drained: got occ=%0d valid=%b expected 0/0", bus4.occupancy, bus4.out_valid);
        end
    endtask

    task automatic test_inverse_nb4();
        logic [127:0] od, fwd, back;
        logic [3:0]   ot;
        logic         ov;
        logic [1:0]   occ;
        xfer4(VEC_IN, 1'b1, 4'hA, od, ot, ov, occ);
        checks++;
        if (od !== VEC_INV || ov !== 1'b1) begin
            errors++;
            $display("[TB] FAIL inv_data: got %h valid=%b expected %h", od, ov, VEC_INV);
        end
        checks++;
        if (ot !== 4'hA) begin
            errors++;
            $display("[TB] FAIL inv_tag: got %h expected a", ot);
        end
        xfer4(VEC_IN, 1'b0, 4'h1, fwd, ot, ov, occ);
        xfer4(fwd, 1'b1, 4'h2, back, ot, ov, occ);
        checks++;
        if (back !== VEC_IN) begin
            errors++;
            $display("[TB] FAIL roundtrip4_a: got %h expected %h", back, VEC_IN);
        end
        xfer4(128'h0123456789abcdeffedcba9876543210, 1'b1, 4'h3, fwd, ot, ov, occ);
        xfer4(fwd, 1'b0, 4'h4, back, ot, ov, occ);
        checks++;
        if (back !== 128'h0123456789abcdeffedcba9876543210) begin
            errors++;
            $display("[TB] FAIL roundtrip4_b: got %h expected 0123456789abcdeffedcba9876543210", back);
        end
    endtask

    task automatic test_nb8_roundtrip();
        logic [255:0] d, fwd, back;
        logic [3:0]   ot;
        logic         ov;
        for (int i = 0; i < 8; i++) begin
            d[32*i +: 32] = $urandom();
        end
        xfer8(d, 1'b0, 4'h6, fwd, ot, ov);
        checks++;
        if (ov !== 1'b1 || ot !== 4'h6) begin
            errors++;
            $display("[TB] FAIL nb8_fwd_beat: got valid=%b tag=%h expected 1/6", ov, ot);
        end
        checks++;
        if (byte8(fwd, 0) !== byte8(d, 0) || byte8(fwd, 1) !== byte8(d, 5)) begin
            errors++;
            $display("[TB] FAIL nb8_rows01: got %h %h expected %h %h",
                     byte8(fwd, 0), byte8(fwd, 1), byte8(d, 0), byte8(d, 5));
        end
        checks++;
        if (byte8(fwd, 2) !== byte8(d, 14) || byte8(fwd, 3) !== byte8(d, 19)) begin
            errors++;
            $display("[TB] FAIL nb8_rows23: got %h %h expected %h %h",
                     byte8(fwd, 2), byte8(fwd, 3), byte8(d, 14), byte8(d, 19));
        end
        xfer8(fwd, 1'b1, 4'h7, back, ot, ov);
        checks++;
        if (back !== d) begin
            errors++;
            $display("[TB] FAIL nb8_roundtrip: got %h expected %h", back, d);
        end
    endtask

    task automatic test_back_pressure();
        logic [3:0]   got_tag  [3];
        logic [127:0] got_data [3];
        int           n = 0;
        logic         acc;
        bus4.out_ready = 1'b0;
        bus4.in_inv    = 1'b0;
        bus4.in_tag    = 4'd1;
        bus4.in_data   = {16{8'h11}};
        bus4.in_valid  = 1'b1;
        @(posedge clk); #1;
        bus4.in_tag    = 4'd2;
        bus4.in_data   = {16{8'h22}};
        @(posedge clk); #1;
        bus4.in_tag    = 4'd3;
        bus4.in_data   = {16{8'h33}};
        checks++;
        if (bus4.in_ready !== 1'b0 || bus4.occupancy !== 2'd2) begin
            errors++;
            $display("[TB] FAIL bp_full: got ready=%b occ=%0d expected 0/2", bus4.in_ready, bus4.occupancy);
        end
        @(posedge clk); #1;
        checks++;
        if (bus4.occupancy !== 2'd2 || bus4.in_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bp_stall: got ready=%b occ=%0d expected 0/2", bus4.in_ready, bus4.occupancy);
        end
        checks++;
        if (bus4.out_valid !== 1'b1 || bus4.out_tag !== 4'd1 || bus4.out_data !== {16{8'h11}}) begin
            errors++;
            $display("[TB] FAIL bp_hold: got valid=%b tag=%h data=%h expected 1/1/1111..", bus4.out_valid, bus4.out_tag, bus4.out_data);
        end
        bus4.out_ready = 1'b1;
        for (int i = 0; i < 12 && n < 3; i++) begin
            if (bus4.out_valid) begin
                got_tag[n]  = bus4.out_tag;
                got_data[n] = bus4.out_data;
                n++;
            end
            acc = bus4.in_valid && bus4.in_ready;
            @(posedge clk); #1;
            if (acc) bus4.in_valid = 1'b0;
        end
        bus4.in_valid  = 1'b0;
        bus4.out_ready = 1'b0;
        checks++;
        if (n !== 3) begin
            errors++;
            $display("[TB] FAIL bp_count: got %0d beats expected 3", n);
        end
        for (int k = 0; k < n; k++) begin
            checks++;
            if (got_tag[k] !== 4'(k + 1) || got_data[k] !== {16{8'(8'h11 * (k + 1))}}) begin
                errors++;
                $display("[TB] FAIL bp_order%0d: got tag=%h data=%h expected tag=%h", k, got_tag[k], got_data[k], 4'(k + 1));
            end
        end
        checks++;
        if (bus4.occupancy !== 2'd0 || bus4.out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bp_empty: got occ=%0d valid=%b expected 0/0", bus4.occupancy, bus4.out_valid);
        end
    endtask

    task automatic test_back_to_back();
        bus4.out_ready = 1'b0;
        bus4.in_inv    = 1'b0;
        bus4.in_tag    = 4'd0;
        bus4.in_data   = {16{8'h00}};
        bus4.in_valid  = 1'b1;
        @(posedge clk); #1;
        bus4.out_ready = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            bus4.in_tag  = 4'(i);
            bus4.in_data = {16{8'(i)}};
            checks++;
            if (bus4.out_valid !== 1'b1 || bus4.in_ready !== 1'b1 ||
                bus4.out_tag !== 4'(i - 1) || bus4.out_data !== {16{8'(i - 1)}}) begin
                errors++;
                $display("[TB] FAIL b2b_beat%0d: got valid=%b ready=%b tag=%h data=%h expected 1/1/%h",
                         i, bus4.out_valid, bus4.in_ready, bus4.out_tag, bus4.out_data, 4'(i - 1));
            end
            @(posedge clk); #1;
            checks++;
            if (bus4.occupancy !== 2'd1) begin
                errors++;
                $display("[TB] FAIL b2b_occ%0d: got %0d expected 1", i, bus4.occupancy);
            end
        end
        bus4.in_valid = 1'b0;
        checks++;
        if (bus4.out_tag !== 4'd4 || bus4.out_data !== {16{8'd20}}) begin
            errors++;
            $display("[TB] FAIL b2b_last: got tag=%h data=%h expected 4/1414..", bus4.out_tag, bus4.out_data);
        end
        @(posedge clk); #1;
        bus4.out_ready = 1'b0;
        checks++;
        if (bus4.occupancy !== 2'd0) begin
            errors++;
            $display("[TB] FAIL b2b_drain: got %0d expected 0", bus4.occupancy);
        end
    endtask

    task automatic test_reset_mid_stream();
        logic [127:0] od;
        logic [3:0]   ot;
        logic         ov;
        logic [1:0]   occ;
        bus4.out_ready = 1'b0;
        bus4.in_inv    = 1'b0;
        bus4.in_tag    = 4'd1;
        bus4.in_data   = {16{8'hA1}};
        bus4.in_valid  = 1'b1;
        @(posedge clk); #1;
        bus4.in_tag    = 4'd2;
        bus4.in_data   = {16{8'hA2}};
        @(posedge clk); #1;
        bus4.in_valid  = 1'b0;
        checks++;
        if (bus4.occupancy !== 2'd2) begin
            errors++;
            $display("[TB] FAIL rst_fill: got %0d expected 2", bus4.occupancy);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (bus4.out_valid !== 1'b0 || bus4.occupancy !== 2'd0 || bus4.in_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rst_async: got valid=%b occ=%0d ready=%b expected 0/0/0",
                     bus4.out_valid, bus4.occupancy, bus4.in_ready);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (bus4.in_ready !== 1'b1 || bus4.out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rst_release: got ready=%b valid=%b expected 1/0", bus4.in_ready, bus4.out_valid);
        end
        xfer4({16{8'h77}}, 1'b0, 4'h9, od, ot, ov, occ);
        checks++;
        if (ov !== 1'b1 || od !== {16{8'h77}} || ot !== 4'h9 || occ !== 2'd1) begin
            errors++;
            $display("[TB] FAIL rst_fresh: got valid=%b data=%h tag=%h occ=%0d expected 1/7777../9/1", ov, od, ot, occ);
        end
    endtask

    initial begin
        bus4.in_valid  = 1'b0;
        bus4.in_data   = '0;
        bus4.in_inv    = 1'b0;
        bus4.in_tag    = '0;
        bus4.out_ready = 1'b0;
        bus8.in_valid  = 1'b0;
        bus8.in_data   = '0;
        bus8.in_inv    = 1'b0;
        bus8.in_tag    = '0;
        bus8.out_ready = 1'b0;
        test_reset();
        test_forward_nb4();
        test_inverse_nb4();
        test_nb8_roundtrip();
        test_back_pressure();
        test_back_to_back();
        test_reset_mid_stream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1, "[TB] time limit reached");
    end

endmodule
